// File: rtl/utf8_rx_decoder.sv
// utf8_rx_decoder: assembles a UTF-8 byte stream into 21-bit code points with length/error status
// behind a one-entry valid/ready output slot and a sticky overrun flag.
module utf8_rx_decoder #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        cp_ready,
  output logic        cp_valid,
  output logic [20:0] cp_data,
  output logic [2:0]  cp_len,
  output logic        cp_err,
  output logic        busy,
  output logic        overrun
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] REPL = 21'h00FFFD;
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [20:0] acc, acc_n, e_data;
  logic [2:0] len, len_n, got, got_n, e_len;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] pend, pend_n, b;
  logic pend_v, pend_v_n, free, replay, have, drop, emit, e_err;
  function automatic logic bad_cp(input logic [20:0] v, input logic [2:0] n);
    return (n == 3'd2 && v < 21'h80) || (n == 3'd3 && v < 21'h800) || (n == 3'd4 && v < 21'h10000) ||
           (v >= 21'h0D800 && v <= 21'h0DFFF) || v > 21'h10FFFF;
  endfunction
  always_comb begin
    free = !cp_valid || cp_ready;
    replay = state == IDLE && pend_v && free;
    have = replay || (byte_valid && !pend_v);
    drop = byte_valid && pend_v;
    b = replay ? pend : byte_in;
    state_n = state;
    acc_n = acc;
    len_n = len;
    got_n = got;
    timer_n = timer;
    pend_v_n = pend_v && !replay;
    pend_n = pend;
    emit = 1'b0;
    e_data = REPL;
    e_len = got;
    e_err = 1'b1;
    if (state == IDLE) begin
      if (have) begin
        if (!b[7]) begin
          emit = 1'b1;
          e_data = {13'd0, b};
          e_len = 3'd1;
          e_err = 1'b0;
        end else if (b[7:5] == 3'b110 || b[7:4] == 4'b1110 || b[7:3] == 5'b11110) begin
          state_n = COLLECT;
          got_n = 3'd1;
          timer_n = '0;
          len_n = b[5] ? (b[4] ? 3'd4 : 3'd3) : 3'd2;
          acc_n = {13'd0, b & (8'h7F >> len_n)};
        end else begin
          emit = 1'b1;
          e_len = 3'd1;
        end
      end
    end else if (byte_valid) begin
      if (b[7:6] == 2'b10) begin
        acc_n = 21'({acc, b[5:0]});
        got_n = got + 3'd1;
        timer_n = '0;
        if (got_n == len) begin
          emit = 1'b1;
          state_n = IDLE;
          e_len = len;
          e_err = bad_cp(acc_n, len);
          e_data = e_err ? REPL : acc_n;
        end
      end else begin
        // interrupting byte is kept and replayed as a lead byte once the slot frees
        emit = 1'b1;
        state_n = IDLE;
        pend_v_n = 1'b1;
        pend_n = b;
      end
    end else if (timer == T_LAST) begin
      emit = 1'b1;
      state_n = IDLE;
    end else begin
      timer_n = timer + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      len <= '0;
      got <= '0;
      timer <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      cp_valid <= 1'b0;
      cp_data <= '0;
      cp_len <= '0;
      cp_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      len <= len_n;
      got <= got_n;
      timer <= timer_n;
      pend <= pend_n;
      pend_v <= pend_v_n;
      if (emit && free) begin
        cp_valid <= 1'b1;
        cp_data <= e_data;
        cp_len <= e_len;
        cp_err <= e_err;
      end else if (cp_ready) begin
        cp_valid <= 1'b0;
      end
      if ((emit && !free) || drop) overrun <= 1'b1;
    end
  end
  assign busy = state == COLLECT || pend_v;
endmodule

// File: tb/tb_utf8_rx_decoder.sv
// tb_utf8_rx_decoder: table vectors, hand-written corner sequences and a randomized stream
// checked against a sequence-level UTF-8 decoding model.
module tb_utf8_rx_decoder;
  localparam int T = 1000;
  logic clk = 0, rst_n = 0, byte_valid = 0, cp_ready = 1;
  logic [7:0] byte_in = 0;
  logic cp_valid, cp_err, busy, overrun;
  logic [20:0] cp_data;
  logic [2:0] cp_len;
  int vec = 0, bad = 0;
  logic mon_en = 0;
  typedef struct { logic [20:0] d; logic [2:0] l; logic e; } res_t;
  typedef struct { logic [31:0] b; int n; logic [20:0] d; logic [2:0] l; logic e; } vec_t;
  res_t expq[$];
  res_t mon_r;
  logic [7:0] stim[$];
  vec_t tbl[16];

  utf8_rx_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid), .cp_ready(cp_ready),
    .cp_valid(cp_valid), .cp_data(cp_data), .cp_len(cp_len), .cp_err(cp_err), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_res(input string nm, input logic [20:0] d, input logic [2:0] l, input logic e);
    check({nm, " valid"}, 32'(cp_valid), 1);
    check({nm, " data"}, 32'(cp_data), 32'(d));
    check({nm, " len"}, 32'(cp_len), 32'(l));
    check({nm, " err"}, 32'(cp_err), 32'(e));
  endtask

  task automatic send(input logic [7:0] bv);
    @(posedge clk); #1;
    byte_in = bv;
    byte_valid = 1;
    @(posedge clk); #1;
    byte_valid = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    byte_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic push(input int d, input int l, input bit e);
    res_t r;
    r.d = 21'(d);
    r.l = 3'(l);
    r.e = e;
    expq.push_back(r);
  endtask

  // Decodes a whole byte list; a trailing partial sequence ends by timeout.
  task automatic model(input logic [7:0] q[$]);
    int i, n, k, v;
    bit ok;
    logic [7:0] c;
    i = 0;
    while (i < q.size()) begin
      c = q[i];
      i++;
      n = c < 8'h80 ? 1 : c < 8'hC0 ? 0 : c < 8'hE0 ? 2 : c < 8'hF0 ? 3 : c < 8'hF8 ? 4 : 0;
      if (n == 1) push(int'(c), 1, 0);
      else if (n == 0) push('hFFFD, 1, 1);
      else begin
        v = int'(c) % (1 << (7 - n));
        k = 1;
        while (k < n && i < q.size() && q[i] >= 8'h80 && q[i] < 8'hC0) begin
          v = v * 64 + int'(q[i]) - 128;
          k++;
          i++;
        end
        ok = k == n && v >= (n == 2 ? 'h80 : n == 3 ? 'h800 : 'h10000) &&
             !(v >= 'hD800 && v <= 'hDFFF) && v <= 'h10FFFF;
        push(ok ? v : 'hFFFD, k, !ok);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && cp_valid) begin
      if (expq.size() == 0) begin
        vec++;
        bad++;
        $display("FAIL rand extra: got %0h len %0d, expected no result", cp_data, cp_len);
      end else begin
        mon_r = expq.pop_front();
        check("rand data", 32'(cp_data), 32'(mon_r.d));
        check("rand len", 32'(cp_len), 32'(mon_r.l));
        check("rand err", 32'(cp_err), 32'(mon_r.e));
      end
    end
  end

  initial begin
    int n, v, tr, cnt;
    logic [7:0] ld;
    logic [31:0] bv;
    tbl = '{
      '{32'h41000000, 1, 21'h41, 3'd1, 1'b0},
      '{32'hE0B88100, 3, 21'h0E01, 3'd3, 1'b0},
      '{32'hF09F9880, 4, 21'h1F600, 3'd4, 1'b0},
      '{32'hC0800000, 2, 21'hFFFD, 3'd2, 1'b1},
      '{32'hEDA08000, 3, 21'hFFFD, 3'd3, 1'b1},
      '{32'hF4908080, 4, 21'hFFFD, 3'd4, 1'b1},
      '{32'h80000000, 1, 21'hFFFD, 3'd1, 1'b1},
      '{32'hC2A90000, 2, 21'hA9, 3'd2, 1'b0},
      '{32'hFF000000, 1, 21'hFFFD, 3'd1, 1'b1},
      '{32'hF48FBFBF, 4, 21'h10FFFF, 3'd4, 1'b0},
      '{32'hE09FBF00, 3, 21'hFFFD, 3'd3, 1'b1},
      '{32'hEFBFBF00, 3, 21'hFFFF, 3'd3, 1'b0},
      '{32'hED9FBF00, 3, 21'hD7FF, 3'd3, 1'b0},
      '{32'hEE808000, 3, 21'hE000, 3'd3, 1'b0},
      '{32'hF08FBFBF, 4, 21'hFFFD, 3'd4, 1'b1},
      '{32'hF8000000, 1, 21'hFFFD, 3'd1, 1'b1}
    };
    do_reset;
    check("reset outs", {cp_valid, cp_data, cp_len, cp_err, busy, overrun}, 0);

    foreach (tbl[t]) begin
      bv = tbl[t].b;
      for (int j = 0; j < tbl[t].n; j++) begin
        send(bv[31-8*j -: 8]);
        if (j < tbl[t].n - 1) check($sformatf("tbl%0d mid%0d valid/busy", t, j), {cp_valid, busy}, 2'b01);
      end
      check_res($sformatf("tbl%0d", t), tbl[t].d, tbl[t].l, tbl[t].e);
    end

    send(8'hE0);
    repeat (867) @(posedge clk);
    send(8'hB8);
    repeat (867) @(posedge clk);
    send(8'h81);
    check_res("thai spaced", 21'h0E01, 3'd3, 1'b0);

    send(8'hE0);
    send(8'hB8);
    send(8'h41);
    check_res("interrupt err", 21'hFFFD, 3'd2, 1'b1);
    check("interrupt busy", 32'(busy), 1);
    @(posedge clk); #1;
    check_res("interrupt replay", 21'h41, 3'd1, 1'b0);
    check("interrupt busy after", 32'(busy), 0);

    send(8'hE0);
    cnt = 0;
    while (!cp_valid && cnt < 3 * T) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("timeout cycles", cnt, T);
    check_res("timeout", 21'hFFFD, 3'd1, 1'b1);

    send(8'hE0);
    send(8'hB8);
    rst_n = 0;
    #2;
    check("async reset outs", {cp_valid, cp_data, cp_len, cp_err, busy, overrun}, 0);
    rst_n = 1;
    send(8'h41);
    check_res("after reset", 21'h41, 3'd1, 1'b0);

    send(8'hE0);
    @(posedge clk); #1;
    byte_in = 8'h41;
    byte_valid = 1;
    @(posedge clk); #1;
    byte_in = 8'h42;
    check_res("replay drop err", 21'hFFFD, 3'd1, 1'b1);
    @(posedge clk); #1;
    byte_valid = 0;
    check_res("replay drop 41", 21'h41, 3'd1, 1'b0);
    check("replay drop overrun", 32'(overrun), 1);
    @(posedge clk); #1;
    check("replay drop gone", {cp_valid, busy}, 0);

    do_reset;
    cp_ready = 0;
    send(8'hE0);
    send(8'h41);
    check_res("pend wait err", 21'hFFFD, 3'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("pend wait hold", {cp_valid, cp_data, busy}, {1'b1, 21'hFFFD, 1'b1});
    cp_ready = 1;
    @(posedge clk); #1;
    check_res("pend wait replay", 21'h41, 3'd1, 1'b0);
    check("pend wait no overrun", 32'(overrun), 0);

    do_reset;
    for (int r = 0; r < 3; r++) begin
      stim.delete();
      for (int j = 0; j < 80; j++) begin
        case ($urandom_range(0, 3))
          0: stim.push_back(8'($urandom_range(0, 127)));
          1: stim.push_back(8'($urandom));
          default: begin
            n = $urandom_range(2, 4);
            v = $urandom_range(0, (1 << (5 * n + 1)) - 1);
            ld = n == 2 ? 8'hC0 : n == 3 ? 8'hE0 : 8'hF0;
            stim.push_back(ld | 8'(v >> (6 * (n - 1))));
            tr = $urandom_range(0, 7) == 0 ? 1 : 0;
            for (int k = n - 2; k >= tr; k--) stim.push_back(8'h80 | 8'((v >> (6 * k)) & 63));
          end
        endcase
      end
      model(stim);
      mon_en = 1;
      foreach (stim[j]) begin
        send(stim[j]);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      repeat (T + 20) @(posedge clk);
      #1;
      mon_en = 0;
      check("rand drained", expq.size(), 0);
      check("rand no overrun", 32'(overrun), 0);
      expq.delete();
    end

    do_reset;
    cp_ready = 0;
    send(8'h41);
    send(8'h42);
    check_res("overrun hold", 21'h41, 3'd1, 1'b0);
    check("overrun set", 32'(overrun), 1);
    cp_ready = 1;
    @(posedge clk); #1;
    check("overrun accepted", 32'(cp_valid), 0);
    check("overrun sticky", 32'(overrun), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
